word_lane_serializer: RTL and testbench

//  Parametrised word-to-lane serializer: accepts DATA_W-bit words from a memory/CPU

---
 rtl/lane_ser_pkg.sv | 16 +
 rtl/word_hold_reg.sv | 35 +++
 rtl/word_lane_serializer.sv | 110 +++++++++++
 tb/tb_word_lane_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_ser_pkg.sv
// Shared sizing helpers and lane-order selectors for the word-to-lane serializer.
package lane_ser_pkg;

    localparam bit LANE_ORDER_LSB = 1'b0;
    localparam bit LANE_ORDER_MSB = 1'b1;

    function automatic int calc_nlanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // A lane index always needs at least one bit, even in degenerate configs.
    function automatic int calc_lidx_w(input int nlanes);
        return (nlanes < 2) ? 1 : $clog2(nlanes);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry word buffer that lets the next word wait while the active word drains.
module word_hold_reg
    import lane_ser_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_take,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    // Load and take never coincide: loading requires the entry to be empty.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/word_lane_serializer.sv
// Serializes DATA_W-bit words into LANE_W-bit lanes with valid/ready on both sides,
// a one-word holding buffer for bubble-free streaming, frame markers and flush.
module word_lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LANE_W    = 8,
    parameter bit MSB_FIRST = LANE_ORDER_LSB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

    localparam int                NLANES   = calc_nlanes(DATA_W, LANE_W);
    localparam int                LIDX_W   = calc_lidx_w(NLANES);
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NLANES - 1);

    logic [DATA_W-1:0] r_active_word;
    logic [LIDX_W-1:0] r_lidx;
    logic              r_active_v;

    logic              w_hold_v;
    logic [DATA_W-1:0] w_hold_data;
    logic              w_clear;
    logic              w_accept;
    logic              w_lane_hs;
    logic              w_last_lane;
    logic              w_word_done;
    logic              w_hold_load;
    logic              w_hold_take;
    logic [LIDX_W-1:0] w_sel;
    logic [LANE_W-1:0] w_lane;

    assign w_clear     = rst | flush;
    assign in_ready    = ~w_hold_v & ~flush & ~rst;
    assign w_accept    = in_valid & in_ready;
    assign w_lane_hs   = r_active_v & out_ready;
    assign w_last_lane = (r_lidx == LAST_IDX);
    assign w_word_done = w_lane_hs & w_last_lane;

    // A word arriving while the last lane leaves bypasses the buffer.
    assign w_hold_load = w_accept & r_active_v & ~w_word_done;
    assign w_hold_take = w_word_done & w_hold_v;

    word_hold_reg #(
        .DATA_W(DATA_W)
    ) u_hold (
        .i_clk  (clk),
        .i_clear(w_clear),
        .i_load (w_hold_load),
        .i_take (w_hold_take),
        .i_data (in_data),
        .o_data (w_hold_data),
        .o_valid(w_hold_v)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_active_word <= '0;
            r_lidx        <= '0;
            r_active_v    <= 1'b0;
        end else if (w_word_done) begin
            r_lidx <= '0;
            if (w_hold_v) begin
                r_active_word <= w_hold_data;
                r_active_v    <= 1'b1;
            end else if (w_accept) begin
                r_active_word <= in_data;
                r_active_v    <= 1'b1;
            end else begin
                r_active_v    <= 1'b0;
            end
        end else if (w_lane_hs) begin
            r_lidx <= r_lidx + 1'b1;
        end else if (w_accept & ~r_active_v) begin
            r_active_word <= in_data;
            r_lidx        <= '0;
            r_active_v    <= 1'b1;
        end
    end

    // The counter tracks emission order; lane order only changes which slice it picks.
    assign w_sel = (MSB_FIRST == LANE_ORDER_MSB) ? (LAST_IDX - r_lidx) : r_lidx;

    always_comb begin
        w_lane = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (w_sel == LIDX_W'(k)) begin
                w_lane = r_active_word[k*LANE_W +: LANE_W];
            end
        end
    end

    assign out_valid = r_active_v;
    assign out_data  = r_active_v ? w_lane : '0;
    assign out_first = r_active_v & (r_lidx == '0);
    assign out_last  = r_active_v & w_last_lane;
    assign busy      = r_active_v | w_hold_v;

endmodule

// File: tb/tb_word_lane_serializer.sv
// Directed bench for word_lane_serializer: three configurations share clk/rst/flush,
// expected lanes are queued on every accept and compared whenever a lane is shown.
module tb_word_lane_serializer;

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        l;
    } lane_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_first, a_out_last, a_busy;
    logic [31:0] a_in_data;
    logic [7:0]  a_out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_first, b_out_last, b_busy;
    logic [31:0] b_in_data;
    logic [7:0]  b_out_data;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_first, c_out_last, c_busy;
    logic [63:0] c_in_data;
    logic [15:0] c_out_data;

    lane_t q_a[$];
    lane_t q_b[$];
    lane_t q_c[$];

    int checks   = 0;
    int failures = 0;

    word_lane_serializer #(.DATA_W(32), .LANE_W(8), .MSB_FIRST(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_first(a_out_first), .out_last(a_out_last), .busy(a_busy)
    );

    word_lane_serializer #(.DATA_W(32), .LANE_W(8), .MSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy)
    );

    word_lane_serializer #(.DATA_W(64), .LANE_W(16), .MSB_FIRST(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_first(c_out_first), .out_last(c_out_last), .busy(c_busy)
    );

    function automatic lane_t mk_lane(input logic [63:0] w, input int dw, input int lw,
                                      input bit msb, input int i);
        int          n;
        int          pos;
        logic [63:0] m;
        lane_t       r;
        n   = dw / lw;
        pos = msb ? (n - 1 - i) : i;
        m   = (64'd1 << lw) - 64'd1;
        r.d = 16'((w >> (pos * lw)) & m);
        r.f = (i == 0);
        r.l = (i == n - 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; samples just after, then
    // advances to the next falling edge.
    task automatic tick();
        #1;
        if (rst || flush) begin
            q_a.delete();
            q_b.delete();
            q_c.delete();
        end else begin
            if (a_out_valid) begin
                if (q_a.size() == 0) check("a_spurious_lane", 64'(a_out_valid), 64'd0);
                else begin
                    check("a_lane", 64'({a_out_data, a_out_first, a_out_last}),
                          64'({q_a[0].d[7:0], q_a[0].f, q_a[0].l}));
                    if (a_out_ready) void'(q_a.pop_front());
                end
            end
            if (a_in_valid && a_in_ready)
                for (int i = 0; i < 4; i++) q_a.push_back(mk_lane(64'(a_in_data), 32, 8, 1'b0, i));

            if (b_out_valid) begin
                if (q_b.size() == 0) check("b_spurious_lane", 64'(b_out_valid), 64'd0);
                else begin
                    check("b_lane", 64'({b_out_data, b_out_first, b_out_last}),
                          64'({q_b[0].d[7:0], q_b[0].f, q_b[0].l}));
                    if (b_out_ready) void'(q_b.pop_front());
                end
            end
            if (b_in_valid && b_in_ready)
                for (int i = 0; i < 4; i++) q_b.push_back(mk_lane(64'(b_in_data), 32, 8, 1'b1, i));

            if (c_out_valid) begin
                if (q_c.size() == 0) check("c_spurious_lane", 64'(c_out_valid), 64'd0);
                else begin
                    check("c_lane", 64'({c_out_data, c_out_first, c_out_last}),
                          64'({q_c[0].d, q_c[0].f, q_c[0].l}));
                    if (c_out_ready) void'(q_c.pop_front());
                end
            end
            if (c_in_valid && c_in_ready)
                for (int i = 0; i < 4; i++) q_c.push_back(mk_lane(c_in_data, 64, 16, 1'b0, i));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_busy",      64'(a_busy),      64'd0);
        check("rst_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_out_data",  64'(a_out_data),  64'd0);
        check("rst_markers",   64'({a_out_first, a_out_last}), 64'd0);
        check("rst_c_valid",   64'(c_out_valid), 64'd0);
        tick();

        // Single word, LSB lane first.
        a_out_ready = 1'b1;
        a_in_data   = 32'hA1B2C3D4;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        check("single_lane0_const", 64'(a_out_data), 64'hD4);
        for (int i = 0; i < 4; i++) begin
            check("single_valid", 64'(a_out_valid), 64'd1);
            tick();
        end
        check("single_busy_drop", 64'(a_busy), 64'd0);
        check("single_drained",   64'(q_a.size()), 64'd0);

        // Same word, MSB lane first.
        b_out_ready = 1'b1;
        b_in_data   = 32'hA1B2C3D4;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid  = 1'b0;
        check("msb_lane0_const", 64'({b_out_data, b_out_first}), 64'({8'hA1, 1'b1}));
        for (int i = 0; i < 4; i++) begin
            check("msb_valid", 64'(b_out_valid), 64'd1);
            tick();
        end
        check("msb_busy_drop", 64'(b_busy), 64'd0);
        check("msb_drained",   64'(q_b.size()), 64'd0);

        // Back-to-back words: eight lanes with no idle cycle.
        a_in_data  = 32'h11223344;
        a_in_valid = 1'b1;
        tick();
        a_in_data  = 32'h55667788;
        for (int i = 0; i < 8; i++) begin
            check("b2b_valid",    64'(a_out_valid), 64'd1);
            check("b2b_in_ready", 64'(a_in_ready), (i >= 1 && i <= 3) ? 64'd0 : 64'd1);
            if (i == 4) check("b2b_second_first", 64'({a_out_data, a_out_first}), 64'({8'h88, 1'b1}));
            tick();
            a_in_valid = 1'b0;
        end
        check("b2b_busy_drop", 64'(a_busy), 64'd0);
        check("b2b_drained",   64'(q_a.size()), 64'd0);

        // Stalls with out_ready pattern 1,0,0,1.
        a_out_ready = 1'b0;
        a_in_data   = 32'h9ABCDEF0;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a_out_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        check("stall_drained",  64'(q_a.size()), 64'd0);
        check("stall_idle",     64'(a_out_valid), 64'd0);

        // Flush with a word in HOLD after two lanes of the active word.
        a_out_ready = 1'b1;
        a_in_data   = 32'hCAFEF00D;
        a_in_valid  = 1'b1;
        tick();
        a_in_data   = 32'h12345678;
        tick();
        a_in_valid  = 1'b0;
        tick();
        check("pre_flush_hold",  64'({a_in_ready, a_busy}), 64'({1'b0, 1'b1}));
        check("pre_flush_lane2", 64'(a_out_data), 64'hFE);
        flush      = 1'b1;
        a_in_data  = 32'hDEADBEEF;
        a_in_valid = 1'b1;
        tick();
        flush      = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("flush_out_valid", 64'(a_out_valid), 64'd0);
        check("flush_busy",      64'(a_busy),      64'd0);
        check("flush_in_ready",  64'(a_in_ready),  64'd1);
        a_in_data  = 32'h0BADC0DE;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("post_flush_lane0", 64'({a_out_data, a_out_first}), 64'({8'hDE, 1'b1}));
        for (int i = 0; i < 4; i++) tick();
        check("post_flush_busy", 64'(a_busy), 64'd0);

        // Reset mid-word: nothing may be re-emitted afterwards.
        a_in_data  = 32'h01020304;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_busy",     64'(a_busy),     64'd0);
        check("midrst_out_data", 64'(a_out_data), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_reemit", 64'(a_out_valid), 64'd0);
            tick();
        end

        // Wide configuration: 64-bit word in 16-bit lanes.
        c_out_ready = 1'b1;
        c_in_data   = 64'h0123456789ABCDEF;
        c_in_valid  = 1'b1;
        tick();
        c_in_valid  = 1'b0;
        check("wide_lane0_const", 64'(c_out_data), 64'hCDEF);
        for (int i = 0; i < 4; i++) begin
            check("wide_valid", 64'(c_out_valid), 64'd1);
            tick();
        end
        check("wide_busy_drop", 64'(c_busy), 64'd0);
        check("wide_drained",   64'(q_c.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
